// File: rtl/seq_mac_pkg.sv
// seq_mac shared types, default widths and the accumulator overflow helper.
// SEQ_MAC_SIGNED_EN switches the helper to two's-complement overflow.
package seq_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } seq_mac_state_t;

    localparam int DEF_W     = 10;
    localparam int DEF_ACC_W = 2 * DEF_W + 4;

    // Overflow of one accumulator add, from operand/sum MSBs and carry out.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic carry
    );
`ifdef SEQ_MAC_SIGNED_EN
        return (a_msb == b_msb) && (s_msb != a_msb);
`else
        return carry | (1'b0 & (a_msb ^ b_msb ^ s_msb));
`endif
    endfunction

endpackage

// File: rtl/seq_mac_shift_add.sv
// seq_mac_shift_add: P register, bit counter and merged add/shift step.
// SEQ_MAC_SIGNED_EN: sign-extended add, arithmetic shift, final subtract.
module seq_mac_shift_add
    import seq_mac_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   mplier,
    input  logic [W-1:0]   mcand,
    output logic           last,
    output logic [2*W-1:0] p_out
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [2*W:0]  p;
    logic [2*W:0]  p_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mcand_q;
    logic [W:0]    addend;
    logic [W:0]    upper;
    logic          sub;
    logic          fill;

    assign last  = (cnt == CW'(W - 1));
    assign p_out = p[2*W-1:0];

    // One RUN step: conditional add (or final subtract), then shift right.
    always_comb begin
        addend = '0;
        upper  = p[2*W:W];
        sub    = 1'b0;
        fill   = 1'b0;
`ifdef SEQ_MAC_SIGNED_EN
        addend = {mcand_q[W-1], mcand_q};
        sub    = last;
`else
        addend = {1'b0, mcand_q};
`endif
        if (p[0]) begin
            if (sub) begin
                upper = p[2*W:W] - addend;
            end else begin
                upper = p[2*W:W] + addend;
            end
        end
`ifdef SEQ_MAC_SIGNED_EN
        fill = upper[W];
`endif
        p_next = {fill, upper, p[W-1:1]};
    end

    // Operand capture on acceptance, then one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            cnt     <= '0;
            mcand_q <= '0;
        end else if (load) begin
            p       <= {{(W + 1){1'b0}}, mplier};
            cnt     <= '0;
            mcand_q <= mcand;
        end else if (step) begin
            p       <= p_next;
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mac.sv
// seq_mac: sequential shift-add multiply-accumulate engine.
// Define SEQ_MAC_SIGNED_EN for two's-complement operands and accumulator.
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = 2 * W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_en,
    input  logic [W-1:0]     mplier,
    input  logic [W-1:0]     mcand,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   prod,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [1:0]       pstate
);

    seq_mac_state_t state;
    seq_mac_state_t next_state;

    logic             load;
    logic             step;
    logic             last;
    logic [2*W-1:0]   p_out;
    logic             acc_en_q;
    logic             busy_d;
    logic             done_d;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic             add_o;

    seq_mac_shift_add #(
        .W(W)
    ) u_shift_add (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .mplier (mplier),
        .mcand  (mcand),
        .last   (last),
        .p_out  (p_out)
    );

    assign pstate = state;

    // State register plus registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last) next_state = ACCUM;
            ACCUM:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath controls and next values of the registered flags.
    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == RUN);
        busy_d = (next_state == RUN) || (next_state == ACCUM);
        done_d = (next_state == DONE);
    end

    // Product extension and the accumulator add with its overflow.
    always_comb begin
`ifdef SEQ_MAC_SIGNED_EN
        prod_ext = ACC_W'($signed(p_out));
`else
        prod_ext = ACC_W'(p_out);
`endif
        sum   = {1'b0, acc} + {1'b0, prod_ext};
        add_o = add_ovf(acc[ACC_W-1], prod_ext[ACC_W-1],
                        sum[ACC_W-1], sum[ACC_W]);
    end

    // Mode capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_en_q <= 1'b0;
        end else if (load) begin
            acc_en_q <= acc_en;
        end
    end

    // Result retirement in ACCUM: product, accumulator, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else if (state == ACCUM) begin
            prod <= p_out;
            if (acc_en_q) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | add_o;
            end else begin
                acc <= prod_ext;
                ovf <= 1'b0;
            end
        end
    end

endmodule
